// File: rtl/cvm300_pkg.sv
// cvm300_pkg: shared types and constants for the CVM300 frame-capture block.
//   cap_state_t      : capture sequencer states
//   DEF_*            : default frame size, FIFO depth and pixel-counter width
//   LANE_FIRST/LAST  : byte lanes of the 32-bit packed word (little-endian)
//   insert_lane()    : places one pixel into a chosen byte lane of a word
package cvm300_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } cap_state_t;

    localparam int DEF_FRAME_PIXELS = 316224;   // 648 x 488
    localparam int DEF_FIFO_DEPTH   = 1024;
    localparam int DEF_CNT_W        = 20;

    localparam logic [1:0] LANE_FIRST = 2'd0;   // first pixel of a word lands in [7:0]
    localparam logic [1:0] LANE_LAST  = 2'd3;   // filling this lane completes the word

    // Return word with px written into byte lane 'lane'; other lanes untouched.
    function automatic logic [31:0] insert_lane(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  px);
        logic [31:0] res;
        res = word;
        case (lane)
            2'd0:    res[7:0]   = px;
            2'd1:    res[15:8]  = px;
            2'd2:    res[23:16] = px;
            2'd3:    res[31:24] = px;
            default: res        = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cvm300_word_fifo.sv
// cvm300_word_fifo: synchronous first-word fall-through FIFO of 32-bit words.
// The head word is held in an output register so it stays stable when the
// FIFO runs empty (the last word popped remains visible).
//   clk, rst_n : clock, asynchronous active-low reset (pointers and head clear)
//   wr, wdata  : push request and data; a push into a full FIFO is dropped
//                unless a pop happens in the same cycle
//   rd         : pop request; ignored while empty
//   rdata      : current head word
//   full, empty, level : occupancy status
module cvm300_word_fifo
    import cvm300_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr,
    input  logic [31:0]             wdata,
    input  logic                    rd,
    output logic [31:0]             rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic [31:0]   rdata_r;

    logic          full_s;
    logic          empty_s;
    logic          do_pop_s;
    logic          do_push_s;
    logic [AW-1:0] rd_next_ptr_s;

    // Occupancy decode and accepted push/pop strobes.
    always_comb begin
        full_s        = (level_r == (AW+1)'(DEPTH));
        empty_s       = (level_r == (AW+1)'(0));
        do_pop_s      = rd & ~empty_s;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        do_push_s     = wr & (~full_s | do_pop_s);
        rd_next_ptr_s = rd_ptr_r + AW'(1);
    end

    // Storage array; no reset needed since occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers, level and the registered head word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= (AW+1)'(0);
            rdata_r  <= 32'h0000_0000;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_next_ptr_s;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
            // Head update: next stored word after a pop, or the incoming word when
            // it becomes the only entry; otherwise the head is held.
            if (do_pop_s && (level_r > (AW+1)'(1))) begin
                rdata_r <= mem_r[rd_next_ptr_s];
            end else if (do_push_s && (empty_s || (do_pop_s && (level_r == (AW+1)'(1))))) begin
                rdata_r <= wdata;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign rdata = rdata_r;
    assign full  = full_s;
    assign empty = empty_s;
    assign level = level_r;

endmodule

// File: rtl/cvm300_frame_capture.sv
// cvm300_frame_capture: captures one CVM300 frame, packs four 8-bit pixels per
// 32-bit word (little-endian) and buffers the words for the host pipe-out.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : arms a capture (only honoured in IDLE)
//   fval, dval, pix : sensor frame-valid, pixel qualifier, pixel data
//   pipe_rd         : pops one word from the buffer (any state)
//   pipe_data       : head word of the buffer (first-word fall-through)
//   busy            : capture in progress (ARM, CAPTURE, DRAIN)
//   done            : one-cycle pulse when the drained capture returns to IDLE
//   overflow        : sticky, a packed word was dropped on a full buffer
//   underflow       : sticky, pipe_rd seen while the buffer was empty
//   word_count      : words produced in the current capture (dropped ones included)
module cvm300_frame_capture
    import cvm300_pkg::*;
#(
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             fval,
    input  logic             dval,
    input  logic [7:0]       pix,
    input  logic             pipe_rd,
    output logic [31:0]      pipe_data,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             underflow,
    output logic [CNT_W-3:0] word_count
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    cap_state_t       state_r;
    logic             fval_r;
    logic [CNT_W-1:0] pix_cnt_r;
    logic [31:0]      pack_r;
    logic [CNT_W-3:0] word_count_r;
    logic             busy_r;
    logic             done_r;
    logic             overflow_r;
    logic             underflow_r;

    cap_state_t       state_next_s;
    logic             fval_rise_s;
    logic             fval_fall_s;
    logic             accept_s;
    logic             word_full_s;
    logic [31:0]      lane_word_s;
    logic             push_s;
    logic [31:0]      push_data_s;
    logic             pop_s;
    logic             arm_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [LVL_W-1:0] fifo_level_s;

    // Next-state, pixel acceptance and FIFO push decode.
    always_comb begin
        fval_rise_s  = fval & ~fval_r;
        fval_fall_s  = ~fval & fval_r;
        pop_s        = pipe_rd & ~fifo_empty_s;
        arm_s        = (state_r == ST_IDLE) & start;
        lane_word_s  = insert_lane(pack_r, pix_cnt_r[1:0], pix);
        accept_s     = 1'b0;
        push_s       = 1'b0;
        push_data_s  = 32'h0000_0000;
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_ARM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                // Pixels qualified in the very cycle fval rises belong to the frame.
                if (fval_rise_s) begin
                    accept_s     = dval;
                    state_next_s = ST_CAPTURE;
                end else begin
                    state_next_s = ST_ARM;
                end
            end
            ST_CAPTURE: begin
                if (fval_fall_s) begin
                    // Short frame: flush a partly filled word; lanes not yet written are zero.
                    push_s       = (pix_cnt_r[1:0] != LANE_FIRST);
                    push_data_s  = pack_r;
                    state_next_s = ST_DRAIN;
                end else if (fval & dval) begin
                    accept_s = 1'b1;
                    if (pix_cnt_r == CNT_W'(FRAME_PIXELS - 1)) begin
                        state_next_s = ST_DRAIN;
                    end else begin
                        state_next_s = ST_CAPTURE;
                    end
                end else begin
                    state_next_s = ST_CAPTURE;
                end
            end
            ST_DRAIN: begin
                // Leave as soon as this cycle's pop (if any) leaves the buffer empty.
                if (fifo_empty_s || ((fifo_level_s == LVL_W'(1)) && pop_s)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        word_full_s = accept_s & (pix_cnt_r[1:0] == LANE_LAST);
        if (word_full_s) begin
            push_s      = 1'b1;
            push_data_s = lane_word_s;
        end else begin
            push_s      = push_s;
            push_data_s = push_data_s;
        end
    end

    // Sequencer state, pack register, counters and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            fval_r       <= 1'b0;
            pix_cnt_r    <= CNT_W'(0);
            pack_r       <= 32'h0000_0000;
            word_count_r <= (CNT_W-2)'(0);
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            fval_r  <= fval;
            busy_r  <= (state_next_s != ST_IDLE);
            done_r  <= (state_r == ST_DRAIN) && (state_next_s == ST_IDLE);
            if (arm_s) begin
                // Arming clears the previous capture's results; an empty read in
                // this same cycle is still recorded.
                pix_cnt_r    <= CNT_W'(0);
                pack_r       <= 32'h0000_0000;
                word_count_r <= (CNT_W-2)'(0);
                overflow_r   <= 1'b0;
                underflow_r  <= pipe_rd & fifo_empty_s;
            end else begin
                if (accept_s) begin
                    pix_cnt_r <= pix_cnt_r + CNT_W'(1);
                    pack_r    <= word_full_s ? 32'h0000_0000 : lane_word_s;
                end
                if (push_s) begin
                    word_count_r <= word_count_r + (CNT_W-2)'(1);
                end
                if (push_s && fifo_full_s && !pop_s) begin
                    overflow_r <= 1'b1;
                end
                if (pipe_rd && fifo_empty_s) begin
                    underflow_r <= 1'b1;
                end
            end
        end
    end

    cvm300_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (push_s),
        .wdata (push_data_s),
        .rd    (pipe_rd),
        .rdata (pipe_data),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    assign busy       = busy_r;
    assign done       = done_r;
    assign overflow   = overflow_r;
    assign underflow  = underflow_r;
    assign word_count = word_count_r;

endmodule
